ux607_ilm_ram_ctrl: RTL

UX607_ILM_RAM_CTRL -- requirements
Module: ux607_ilm_ram_ctrl

---
 rtl/ux607_ilm_ram_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/ux607_ilm_ram_ctrl.sv
// ILM SRAM controller: round-robin arbitration between IFU fetch and BIU ports onto a single-port RAM,
// with one-cycle read latency, response hold under backpressure, and idle light-sleep control.
module ux607_ilm_ram_ctrl #(
  parameter int AW      = 16,
  parameter int DW      = 64,
  parameter int MW      = 8,
  parameter int LS_IDLE = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_cmd_valid,
  output logic          ifu_cmd_ready,
  input  logic [AW-1:0] ifu_cmd_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          biu_cmd_valid,
  output logic          biu_cmd_ready,
  input  logic          biu_cmd_read,
  input  logic [AW-1:0] biu_cmd_addr,
  input  logic [DW-1:0] biu_cmd_wdata,
  input  logic [MW-1:0] biu_cmd_wmask,
  output logic          biu_rsp_valid,
  input  logic          biu_rsp_ready,
  output logic [DW-1:0] biu_rsp_rdata,
  output logic          ram_cs,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls,
  output logic          ram_ds,
  output logic          ram_sd
);
  localparam int CW = $clog2(LS_IDLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_RSP, S_HOLD} state_e;

  state_e        state_q;
  logic          owner_q;   // 0 = IFU, 1 = BIU
  logic          wr_q;
  logic          rr_q;      // 1 = BIU wins the next tie
  logic [CW-1:0] idle_cnt_q;
  logic [DW-1:0] hold_q;

  logic          busy, ls_full, any_vld, owner_hs, can_acc, gnt_biu;
  logic          acc_ifu, acc_biu, acc;
  logic [DW-1:0] rsp_data;

  assign busy    = (state_q != S_IDLE);
  assign ls_full = (idle_cnt_q == CW'(LS_IDLE));
  assign any_vld = ifu_cmd_valid | biu_cmd_valid;

  assign ifu_rsp_valid = rst_n & busy & ~owner_q;
  assign biu_rsp_valid = rst_n & busy &  owner_q;
  assign owner_hs      = owner_q ? (biu_rsp_valid & biu_rsp_ready)
                                 : (ifu_rsp_valid & ifu_rsp_ready);

  // A new command may overlap the cycle in which the previous response completes.
  assign can_acc = rst_n & ~ls_full & (~busy | owner_hs);
  assign gnt_biu = biu_cmd_valid & (~ifu_cmd_valid | rr_q);

  assign ifu_cmd_ready = can_acc & ~gnt_biu;
  assign biu_cmd_ready = can_acc &  gnt_biu;
  assign acc_ifu       = ifu_cmd_valid & ifu_cmd_ready;
  assign acc_biu       = biu_cmd_valid & biu_cmd_ready;
  assign acc           = acc_ifu | acc_biu;

  assign ram_cs   = acc;
  assign ram_addr = acc_biu ? biu_cmd_addr : ifu_cmd_addr;
  assign ram_wem  = (acc_biu & ~biu_cmd_read) ? biu_cmd_wmask : '0;
  assign ram_din  = biu_cmd_wdata;

  assign rsp_data      = wr_q ? '0 : ((state_q == S_HOLD) ? hold_q : ram_dout);
  assign ifu_rsp_rdata = rsp_data;
  assign biu_rsp_rdata = rsp_data;

  // Any pending request drops LS immediately; the saturated counter still blocks
  // acceptance for that wake cycle, giving the RAM one cycle to leave sleep.
  assign ram_ls = rst_n & ls_full & ~any_vld;
  assign ram_ds = 1'b0;
  assign ram_sd = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      rr_q       <= 1'b0;
      idle_cnt_q <= '0;
      hold_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (acc) state_q <= S_RSP;
        S_RSP: begin
          if (owner_hs) begin
            state_q <= acc ? S_RSP : S_IDLE;
          end else begin
            state_q <= S_HOLD;
            hold_q  <= ram_dout;
          end
        end
        S_HOLD: if (owner_hs) state_q <= acc ? S_RSP : S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (acc) begin
        owner_q <= acc_biu;
        wr_q    <= acc_biu & ~biu_cmd_read;
        rr_q    <= acc_ifu;
      end

      if (busy || any_vld)  idle_cnt_q <= '0;
      else if (!ls_full)    idle_cnt_q <= idle_cnt_q + CW'(1);
    end
  end
endmodule
